// File: rtl/apb3_master_sequencer.sv
// APB3 master sequencer: one request in, one SETUP/ACCESS transfer, one response out.
// Optional ACCESS-phase timeout abort is enabled by defining APB3_MASTER_TIMEOUT_EN.
module apb3_master_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int SLOT_SHIFT     = 24,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [16:0]           PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [31:0]           PRDATA
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]            state_q, state_d;
  logic [16:0]           psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [4:0]            slot;
  logic                  accept;

`ifdef APB3_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign slot      = req_addr[SLOT_SHIFT+4:SLOT_SHIFT];
  assign req_ready = PRESETN && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and output-register computation for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
`ifdef APB3_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (slot > 5'd16) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = S_SETUP;
            psel_d   = 17'd1 << slot;
            paddr_d  = req_addr;
            pwrite_d = req_write;
            pwdata_d = req_wdata;
`ifdef APB3_MASTER_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (PREADY) begin
          state_d     = S_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (pwrite_q || PSLVERR) ? 32'd0 : PRDATA;
        end
`ifdef APB3_MASTER_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and registered APB/response outputs; reset forces everything to 0.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= S_IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB3_MASTER_TIMEOUT_EN
  // Wait-state counter for the ACCESS-phase abort.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_apb3_master_sequencer.sv
// Scoreboard bench for apb3_master_sequencer with a randomized APB slave.
// Define APB3_MASTER_TIMEOUT_EN to also exercise the timeout abort (TIMEOUT_CYCLES=4).
module tb_apb3_master_sequencer;

  localparam int TO = 4;
`ifdef APB3_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [16:0] PSEL;
  logic        PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  always #5 PCLK = ~PCLK;

  apb3_master_sequencer #(
    .ADDR_WIDTH(32), .SLOT_SHIFT(24), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  typedef struct {
    int          waits;
    logic [31:0] rd;
    logic        er;
  } plan_t;

  typedef struct {
    logic [16:0] psel;
    logic [31:0] a;
    logic [31:0] wd;
    logic        w;
    int          cyc;
  } setup_t;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        er;
  } rsp_t;

  plan_t  slv_q[$];
  setup_t set_q[$];
  rsp_t   rsp_q[$];

  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  int     model_idle = 0;
  setup_t cur;
  bit     cur_ok = 1'b0;
  rsp_t   mr;

  always @(posedge PCLK) cyc++;

  function automatic void chk(input string n,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               n, act, exp, cyc);
    end
  endfunction

  // Issue one request; expectations come from the transaction rules.
  task automatic send(input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input int waits,
                      input logic [31:0] rd, input logic er);
    logic [4:0] slot;
    int         acc, exp_acc, g;
    setup_t     s;
    plan_t      p;
    rsp_t       r;
    slot      = a[28:24];
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    exp_acc   = (cyc > model_idle) ? cyc : model_idle;
    if (slot <= 5'd16) begin
      p = '{waits, rd, er};
      slv_q.push_back(p);
    end
    g = 0;
    forever begin
      @(negedge PCLK);
      if (req_ready) break;
      g++;
      if (g > 200) break;
    end
    chk("accept_bound", 64'(g > 200), 64'd0);
    acc = cyc;
    chk("accept_cycle", 64'(acc), 64'(exp_acc));
    if (slot > 5'd16) begin
      r = '{acc + 1, 32'd0, 1'b1};
    end else begin
      s = '{17'd1 << slot, a, wd, w, acc + 1};
      set_q.push_back(s);
      if (TMO_EN && waits >= TO)
        r = '{acc + 2 + TO, 32'd0, 1'b1};
      else
        r = '{acc + 3 + waits, (w || er) ? 32'd0 : rd, er};
    end
    rsp_q.push_back(r);
    model_idle = r.cyc;
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  // APB slave: follows the per-transfer plan, junk on the bus otherwise.
  plan_t sp;
  int    left = 0;
  bit    active = 1'b0;
  initial begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    forever begin
      @(posedge PCLK);
      #1;
      if (PSEL != 17'd0 && PENABLE) begin
        if (!active) begin
          if (slv_q.size() != 0) sp = slv_q.pop_front();
          else sp = '{0, 32'd0, 1'b0};
          left   = sp.waits;
          active = 1'b1;
        end
        if (left > 0) begin
          PREADY  = 1'b0;
          PSLVERR = 1'($urandom);
          PRDATA  = $urandom;
          left--;
        end else begin
          PREADY  = 1'b1;
          PSLVERR = sp.er;
          PRDATA  = sp.rd;
          active  = 1'b0;
        end
      end else begin
        active  = 1'b0;
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
      end
    end
  end

  // Monitor: checks APB phases and pops responses from the scoreboard.
  always @(negedge PCLK) begin
    if (PRESETN) begin
      if (rsp_q.size() != 0 && cyc > rsp_q[0].cyc) begin
        mr = rsp_q.pop_front();
        chk("rsp_missing", 64'(cyc), 64'(mr.cyc));
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          mr = rsp_q.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(mr.cyc));
          chk("rsp_err", 64'(rsp_err), 64'(mr.er));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(mr.rd));
          chk("rsp_bus_idle", {PSEL, PENABLE}, 64'd0);
        end
      end
      if (PSEL != 17'd0 && !PENABLE) begin
        if (set_q.size() == 0) begin
          chk("setup_unexpected", 64'd1, 64'd0);
        end else begin
          cur    = set_q.pop_front();
          cur_ok = 1'b1;
          chk("setup_cycle", 64'(cyc), 64'(cur.cyc));
          chk("setup_psel", 64'(PSEL), 64'(cur.psel));
          chk("setup_paddr", 64'(PADDR), 64'(cur.a));
          chk("setup_pwrite", 64'(PWRITE), 64'(cur.w));
          chk("setup_pwdata", 64'(PWDATA), 64'(cur.wd));
        end
      end else if (PSEL != 17'd0 && PENABLE) begin
        chk("access_psel", 64'(PSEL), 64'(cur.psel));
        chk("access_paddr", 64'(PADDR), 64'(cur.a));
        chk("access_pwrite", 64'(PWRITE), 64'(cur.w));
        chk("access_pwdata", 64'(PWDATA), 64'(cur.wd));
      end else if (PENABLE) begin
        chk("penable_without_psel", 64'd1, 64'd0);
      end else if (cur_ok) begin
        chk("idle_paddr_hold", 64'(PADDR), 64'(cur.a));
        chk("idle_pwdata_hold", 64'(PWDATA), 64'(cur.wd));
      end
    end
  end

  logic [31:0] a;
  int          g;

  initial begin
    PRESETN   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_ctrl",
        {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, req_ready},
        64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    PRESETN = 1'b1;
    #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    model_idle = cyc;

    send(1'b0, 32'h0300_0010, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    send(1'b1, 32'h1000_0004, 32'h1234_5678, 3, 32'hFFFF_FFFF, 1'b0);
    send(1'b0, 32'h0500_0020, 32'h0, 1, 32'hCAFE_F00D, 1'b1);
    send(1'b0, 32'h1100_0000, 32'h0, 0, 32'h0, 1'b0);
    send(1'b1, 32'h0000_0008, 32'hA5A5_5A5A, 0, 32'h0, 1'b1);
    send(1'b0, 32'h0F00_0100, 32'h0, 2, 32'h0BAD_CAFE, 1'b0);

    for (int i = 0; i < 60; i++) begin
      a        = $urandom;
      a[28:24] = 5'($urandom_range(0, 19));
      repeat ($urandom_range(0, 2)) begin
        @(posedge PCLK);
        #1;
      end
      send(1'($urandom), a, $urandom,
           TMO_EN ? $urandom_range(0, TO - 1) : $urandom_range(0, 5),
           $urandom, 1'($urandom_range(0, 3) == 0));
    end

`ifdef APB3_MASTER_TIMEOUT_EN
    send(1'b0, 32'h0200_0040, 32'h0, TO + 6, 32'h1111_2222, 1'b0);
    send(1'b1, 32'h0700_0000, 32'h7777_0000, TO - 1, 32'h0, 1'b0);
`endif

    send(1'b0, 32'h0100_0000, 32'h0, 30, 32'h5555_AAAA, 1'b0);
    @(posedge PCLK);
    #1;
    chk("pre_rst_access", {PSEL, PENABLE}, {17'h00002, 1'b1});
    PRESETN = 1'b0;
    #1;
    chk("midrst_ctrl",
        {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, req_ready},
        64'd0);
    chk("midrst_paddr", 64'(PADDR), 64'd0);
    rsp_q.delete();
    set_q.delete();
    slv_q.delete();
    cur_ok = 1'b0;
    @(posedge PCLK);
    #1;
    PRESETN = 1'b1;
    model_idle = cyc;
    repeat (5) begin
      @(negedge PCLK);
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge PCLK);
    #1;
    send(1'b0, 32'h0400_0000, 32'h0, 0, 32'h0123_4567, 1'b0);

    g = 0;
    while (rsp_q.size() != 0 && g < 500) begin
      @(negedge PCLK);
      g++;
    end
    chk("drain", 64'(rsp_q.size()), 64'd0);
    repeat (3) @(negedge PCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb3_master_sequencer.md
Name: apb3_master_sequencer

Overview:
- APB3 master-side sequencer for the 17-slot APB3 interconnect.
- Accepts single read/write requests from a simple request port and decodes the slot.
- Drives one-hot PSEL[16:0], PENABLE, PADDR, PWRITE and PWDATA into the slot fabric.
- Consumes the muxed PREADY/PSLVERR/PRDATA returned by the interconnect's response mux and returns one response per request.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and PADDR.
- SLOT_SHIFT, 24, LSB of the 5-bit slot index field in req_addr; slot = req_addr[SLOT_SHIFT+4:SLOT_SHIFT].
- TIMEOUT_CYCLES, 256, ACCESS-phase cycles with PREADY low before abort; used only when the optional feature is compiled in.

Ports:
- PCLK  in  1  clock.
- PRESETN  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&req_ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  slave error, decode error or timeout.
- PSEL  out  17  one-hot slot select.
- PENABLE  out  1  APB access phase.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PREADY  in  1  muxed ready.
- PSLVERR  in  1  muxed error.
- PRDATA  in  32  muxed read data.

Behaviour:
- Reset: all outputs 0 (PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_*=0); state IDLE; req_ready=0 during reset and 1 in IDLE once PRESETN is released.
- States:
  - IDLE: req_ready=1. Accept on req_valid. Slot index <=16 -> SETUP. Slot index >16 (decode error) -> stays IDLE, no PSEL asserted, next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - SETUP: PSEL[slot]=1, PENABLE=0, PADDR/PWRITE/PWDATA registered from the request. Always -> ACCESS after one cycle.
  - ACCESS: PENABLE=1, PSEL held. PREADY=0: stay. PREADY=1: capture PSLVERR and PRDATA (read only; write captures 0) -> IDLE; PSEL=0 and PENABLE=0 on the next cycle.
- Latency: accept at cycle T; SETUP at T+1; ACCESS at T+2; with zero wait states rsp_valid at T+3. Each PREADY-low cycle adds one cycle.
- rsp_valid pulses exactly one cycle, in the cycle after completion. It coincides with IDLE, so a new request may be accepted in the same cycle (back-to-back). No response backpressure.
- PADDR, PWRITE and PWDATA hold their values after a transfer until the next SETUP.
- req_ready=0 in SETUP and ACCESS; req_* is ignored there.
- PSLVERR is sampled only when PENABLE&PREADY; otherwise ignored.
- Reset asserted mid-transfer: immediate return to IDLE, all outputs 0, no response generated.

Optional Feature:
- Macro APB3_MASTER_TIMEOUT_EN.
- Defined:
  - Counter cleared on SETUP entry; increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0: abort -> IDLE, PSEL and PENABLE deassert next cycle, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - PREADY=1 in the same cycle the threshold is reached: normal completion wins.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Read, addr 0x0300_0010, PREADY=1 immediately, PRDATA=0xDEADBEEF -> PSEL=17'h00008 at T+1..T+2, PENABLE only at T+2, rsp_valid at T+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write, addr 0x1000_0004 (slot 16), wdata 0x12345678, PREADY low 3 cycles -> PSEL[16]=1, PWDATA stable through ACCESS, rsp_valid at T+6, rsp_rdata=0.
- Read with PREADY=1, PSLVERR=1 -> rsp_err=1; PSLVERR=1 while PENABLE=0 has no effect.
- Addr 0x1100_0000 (slot 17) -> PSEL stays 0, rsp_valid at T+1, rsp_err=1.
- Two requests back-to-back, second presented during the rsp_valid cycle -> accepted in that cycle, second SETUP the following cycle.
- APB3_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, PREADY held 0 -> rsp_err=1 after 4 ACCESS cycles, PSEL=0; separately, PRESETN pulsed low during ACCESS -> no rsp_valid, outputs 0.
